ahb_sram_sub: RTL and testbench
===============================

// Module: ahb_sram_sub
// PURPOSE
//  AHB-Lite subordinate that sits directly downstream of the manager on the AHB bus.
//  Backed by byte-addressable on-chip SRAM, with programmable wait states and HWSTRB byte enables.
//  Returns a two-cycle ERROR response for out-of-range, misaligned or oversized transfers.
//  Serves as the standard memory target for VIP benches and as a template for peripheral slaves.
// PARAMETERS
//  ADDR_WIDTH   32    HADDR width
//  DATA_WIDTH   32    HWDATA/HRDATA width; legal values 32 or 64
//  MEM_BYTES    4096  SRAM size in bytes; power of 2; valid range 0..MEM_BYTES-1
//  WAIT_STATES  0     HREADYOUT-low cycles inserted before every OKAY data phase; range 0..15
// PORTS
//  HCLK       in   1             bus clock; all logic on rising edge
//  HRESETn    in   1             synchronous active-low reset
//  HSELx      in   1             subordinate select from decoder
//  HADDR      in   ADDR_WIDTH    byte address (address phase)
//  HTRANS     in   2             IDLE/BUSY/NONSEQ/SEQ
//  HWRITE     in   1             1 = write
//  HSIZE      in   3             transfer size, log2(bytes)
//  HBURST     in   3             burst type; ignored (each beat is decoded independently)
//  HPROT      in   4             ignored
//  HMASTLOCK  in   1             ignored
//  HWDATA     in   DATA_WIDTH    write data (data phase)
//  HWSTRB     in   DATA_WIDTH/8  write byte strobes (data phase)
//  HREADY     in   1             bus-wide ready from interconnect
//  HRDATA     out  DATA_WIDTH    read data; valid when HREADYOUT=1 in a read data phase
//  HREADYOUT  out  1             this subordinate's ready
//  HRESP      out  1             0 = OKAY, 1 = ERROR
// BEHAVIOUR
//  Reset: state = IDLE, HREADYOUT = 1, HRESP = 0, HRDATA = 0, wait counter = 0. SRAM contents are not reset.
//  Accept: an address phase is accepted when HSELx & HREADY & HTRANS[1] (NONSEQ or SEQ) at the rising edge.
//    On accept, register HADDR, HSIZE and HWRITE.
//    IDLE/BUSY, or HSELx = 0: zero-wait OKAY; no memory access.
//  Error check (in the address phase): any one of the following makes the transfer an error:
//    - HADDR >= MEM_BYTES
//    - HADDR & ((1<<HSIZE)-1) != 0 (misaligned)
//    - (1<<HSIZE) > DATA_WIDTH/8 (oversized)
//  FSM states: IDLE, WAIT, DATA, ERR1, ERR2.
//    IDLE  --accept OK,  WAIT_STATES>0--> WAIT; load counter = WAIT_STATES-1.
//    IDLE  --accept OK,  WAIT_STATES=0--> DATA.
//    IDLE  --accept err-->                ERR1. Error transfers skip wait states.
//    WAIT: HREADYOUT = 0, HRESP = 0. Counter decrements; at 0 go to DATA.
//    DATA: HREADYOUT = 1, HRESP = 0. Transfer completes this cycle.
//          Next state is evaluated exactly as from IDLE (back-to-back pipelining).
//    ERR1: HREADYOUT = 0, HRESP = 1 -> ERR2 unconditionally.
//    ERR2: HREADYOUT = 1, HRESP = 1. Next state as from IDLE. The manager may present IDLE to cancel.
//  Write: performed on the DATA-cycle edge only. Byte i is written iff HWSTRB[i] & lane_mask[i].
//    lane_mask = size-derived mask at HADDR mod DATA_WIDTH/8. Error transfers never write.
//  Read: HRDATA is driven combinationally from SRAM in the DATA cycle.
//    Word address = HADDR / (DATA_WIDTH/8). Lanes outside lane_mask read 0.
//    HRDATA = 0 in every non-DATA cycle.
//  Read-after-write: a read directly following a write to the same word returns the new data.
//    The write occurs at the edge that ends the write's data phase.
//  Mid-operation reset: FSM returns to IDLE; the pending transfer is dropped; no SRAM write occurs.
//  HREADY vs HREADYOUT: while this subordinate owns the data phase, HREADY equals HREADYOUT.
//    Benches with a single subordinate tie HREADY to HREADYOUT.
// STRUCTURE
//  Package ahb_pkg holds:
//    - htrans_e: IDLE=0, BUSY=1, NONSEQ=2, SEQ=3
//    - hsize_e: BYTE=0 .. DWORD=3
//    - hburst_e
//    - hresp_e: OKAY=0, ERROR=1
//    - sub_state_e: the FSM states above
//    - function lane_mask(addr, size, bytes)
//  Sub-module ahb_sram_mem: MEM_BYTES/(DATA_WIDTH/8) words by DATA_WIDTH, per-byte write enable,
//    asynchronous read, synchronous write.
//  Top level contains: address-phase decode, FSM, wait counter, output muxing.
// TESTING
//  1 WAIT_STATES=0: write 0xDEADBEEF to 0x10 (word), then read 0x10
//      -> OKAY, zero wait, HRDATA=0xDEADBEEF.
//  2 Byte write 0xAA to 0x13 (HSIZE=0, HWSTRB=4'hF) after test 1
//      -> word read of 0x10 = 0xAAADBEEF (strobe masked by lane).
//  3 WAIT_STATES=3: read 0x10
//      -> HREADYOUT low exactly 3 cycles, then high with data.
//  4 Read 0x1000 with MEM_BYTES=4096
//      -> cycle 1: HREADYOUT=0, HRESP=1; cycle 2: HREADYOUT=1, HRESP=1; SRAM unchanged.
//  5 Halfword write to 0x21 (misaligned) -> two-cycle ERROR, no write.
//    Back-to-back NONSEQ/SEQ INCR4 writes at 0x40..0x4C, then reads -> 4 OKAY beats, data matches.
//  6 Assert HRESETn=0 during WAIT of a write to 0x50
//      -> next cycle HREADYOUT=1, HRESP=0; word 0x50 retains its old value.

Source files
------------

// File: rtl/ahb_pkg.sv
// AHB-Lite shared types and helpers for the SRAM subordinate.
// Contents: transfer/size/burst/response encodings, subordinate FSM states, and
// lane_mask(), which returns the byte lanes a transfer of a given size occupies.
package ahb_pkg;

    typedef enum logic [1:0] {
        TransIdle   = 2'd0,
        TransBusy   = 2'd1,
        TransNonseq = 2'd2,
        TransSeq    = 2'd3
    } htrans_e;

    typedef enum logic [2:0] {
        SizeByte  = 3'd0,
        SizeHalf  = 3'd1,
        SizeWord  = 3'd2,
        SizeDword = 3'd3
    } hsize_e;

    typedef enum logic [2:0] {
        BurstSingle = 3'd0,
        BurstIncr   = 3'd1,
        BurstWrap4  = 3'd2,
        BurstIncr4  = 3'd3,
        BurstWrap8  = 3'd4,
        BurstIncr8  = 3'd5,
        BurstWrap16 = 3'd6,
        BurstIncr16 = 3'd7
    } hburst_e;

    typedef enum logic {
        RespOkay  = 1'b0,
        RespError = 1'b1
    } hresp_e;

    typedef enum logic [2:0] {
        StIdle,
        StWait,
        StData,
        StErr1,
        StErr2
    } sub_state_e;

    // Byte lanes covered by a transfer: size-wide run of ones placed at the
    // address offset within the bus word. bytes is the bus width in bytes (4 or 8).
    function automatic logic [7:0] lane_mask(input logic [2:0] addr_lo,
                                             input logic [2:0] size,
                                             input int unsigned bytes);
        logic [7:0] w_ones;
        logic [2:0] w_off;
        case (size)
            3'd0:    w_ones = 8'h01;
            3'd1:    w_ones = 8'h03;
            3'd2:    w_ones = 8'h0F;
            default: w_ones = 8'hFF;
        endcase
        w_off = addr_lo & 3'(bytes - 1);
        return w_ones << w_off;
    endfunction

endpackage

// File: rtl/ahb_sram_mem.sv
// Byte-writable SRAM array behind the AHB subordinate.
// Ports: i_clk clock; i_we per-byte write enable; i_addr word address (shared by
// read and write); i_wdata write data; o_rdata asynchronous read data.
module ahb_sram_mem #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned WORDS      = 1024
) (
    input  logic                       i_clk,
    input  logic [DATA_WIDTH/8-1:0]    i_we,
    input  logic [$clog2(WORDS)-1:0]   i_addr,
    input  logic [DATA_WIDTH-1:0]      i_wdata,
    output logic [DATA_WIDTH-1:0]      o_rdata
);

    logic [DATA_WIDTH-1:0] r_mem [WORDS];

    always_ff @(posedge i_clk) begin
        for (int i = 0; i < DATA_WIDTH / 8; i++) begin
            if (i_we[i]) begin
                r_mem[i_addr][8*i +: 8] <= i_wdata[8*i +: 8];
            end
        end
    end

    assign o_rdata = r_mem[i_addr];

endmodule

// File: rtl/ahb_sram_sub.sv
// AHB-Lite SRAM subordinate with programmable wait states and byte strobes.
// Ports: HCLK/HRESETn clock and synchronous active-low reset; HSELx, HADDR, HTRANS,
// HWRITE, HSIZE, HBURST, HPROT, HMASTLOCK address-phase controls (burst, prot and
// lock are ignored); HWDATA/HWSTRB data-phase write data and strobes; HREADY bus
// ready; HRDATA read data; HREADYOUT own ready; HRESP OKAY/ERROR response.
module ahb_sram_sub
    import ahb_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH  = 32,
    parameter int unsigned DATA_WIDTH  = 32,
    parameter int unsigned MEM_BYTES   = 4096,
    parameter int unsigned WAIT_STATES = 0
) (
    input  logic                    HCLK,
    input  logic                    HRESETn,
    input  logic                    HSELx,
    input  logic [ADDR_WIDTH-1:0]   HADDR,
    input  logic [1:0]              HTRANS,
    input  logic                    HWRITE,
    input  logic [2:0]              HSIZE,
    input  logic [2:0]              HBURST,
    input  logic [3:0]              HPROT,
    input  logic                    HMASTLOCK,
    input  logic [DATA_WIDTH-1:0]   HWDATA,
    input  logic [DATA_WIDTH/8-1:0] HWSTRB,
    input  logic                    HREADY,
    output logic [DATA_WIDTH-1:0]   HRDATA,
    output logic                    HREADYOUT,
    output logic                    HRESP
);

    localparam int unsigned BYTES = DATA_WIDTH / 8;
    localparam int unsigned WORDS = MEM_BYTES / BYTES;
    localparam int unsigned LSB   = $clog2(BYTES);
    localparam int unsigned WAW   = $clog2(WORDS);

    logic                  w_accept;
    logic                  w_err;
    logic [7:0]            w_align_mask;
    logic [7:0]            w_lanes_full;
    logic [BYTES-1:0]      w_lanes;
    logic [BYTES-1:0]      w_we;
    logic [DATA_WIDTH-1:0] w_rdata;
    logic [DATA_WIDTH-1:0] w_rmask;
    logic                  w_unused_ok;

    sub_state_e            r_state;
    logic [LSB+WAW-1:0]    r_addr;
    logic [2:0]            r_size;
    logic                  r_write;
    logic [3:0]            r_cnt;
    logic                  r_hreadyout;
    hresp_e                r_hresp;

    // Address-phase decode.
    assign w_accept     = HSELx & HREADY & HTRANS[1];
    assign w_align_mask = 8'((9'd1 << HSIZE) - 9'd1);
    assign w_err        = (HADDR >= ADDR_WIDTH'(MEM_BYTES))
                        | (|(HADDR[7:0] & w_align_mask))
                        | (HSIZE > 3'(LSB));

    always_ff @(posedge HCLK) begin
        if (!HRESETn) begin
            r_state     <= StIdle;
            r_hreadyout <= 1'b1;
            r_hresp     <= RespOkay;
            r_cnt       <= '0;
            r_addr      <= '0;
            r_size      <= '0;
            r_write     <= 1'b0;
        end else begin
            unique case (r_state)
                StWait: begin
                    if (r_cnt == 4'd0) begin
                        r_state     <= StData;
                        r_hreadyout <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt - 4'd1;
                    end
                end
                StErr1: begin
                    r_state     <= StErr2;
                    r_hreadyout <= 1'b1;
                    r_hresp     <= RespError;
                end
                // StIdle, StData and StErr2 all complete on this edge and may take
                // the next address phase directly.
                default: begin
                    if (w_accept) begin
                        r_addr  <= HADDR[LSB+WAW-1:0];
                        r_size  <= HSIZE;
                        r_write <= HWRITE;
                        if (w_err) begin
                            r_state     <= StErr1;
                            r_hreadyout <= 1'b0;
                            r_hresp     <= RespError;
                        end else if (WAIT_STATES != 0) begin
                            r_state     <= StWait;
                            r_cnt       <= 4'(WAIT_STATES - 1);
                            r_hreadyout <= 1'b0;
                            r_hresp     <= RespOkay;
                        end else begin
                            r_state     <= StData;
                            r_hreadyout <= 1'b1;
                            r_hresp     <= RespOkay;
                        end
                    end else begin
                        r_state     <= StIdle;
                        r_hreadyout <= 1'b1;
                        r_hresp     <= RespOkay;
                    end
                end
            endcase
        end
    end

    assign w_lanes_full = lane_mask(r_addr[2:0], r_size, BYTES);
    assign w_lanes      = w_lanes_full[BYTES-1:0];

    always_comb begin
        w_we    = '0;
        w_rmask = '0;
        for (int i = 0; i < int'(BYTES); i++) begin
            // HRESETn gate: a reset landing on the data edge drops the write.
            w_we[i]            = HRESETn & (r_state == StData) & r_write & HWSTRB[i] & w_lanes[i];
            w_rmask[8*i +: 8]  = {8{w_lanes[i]}};
        end
    end

    ahb_sram_mem #(
        .DATA_WIDTH (DATA_WIDTH),
        .WORDS      (WORDS)
    ) u_mem (
        .i_clk   (HCLK),
        .i_we    (w_we),
        .i_addr  (r_addr[LSB +: WAW]),
        .i_wdata (HWDATA),
        .o_rdata (w_rdata)
    );

    assign HRDATA    = ((r_state == StData) && !r_write) ? (w_rdata & w_rmask) : '0;
    assign HREADYOUT = r_hreadyout;
    assign HRESP     = r_hresp;

    assign w_unused_ok = ^{HBURST, HPROT, HMASTLOCK, w_lanes_full};

endmodule

// File: tb/tb_ahb_sram_sub.sv
// Self-checking bench for ahb_sram_sub: two instances (0 and 3 wait states), each with
// HREADY tied to its own HREADYOUT. Directed table, burst and reset sequences, then
// random transfers against a byte-array reference model.
module tb_ahb_sram_sub;

    localparam int unsigned MEMB = 4096;

    logic        HCLK = 1'b0;
    logic        HRESETn;
    logic        sel0, sel3;
    logic [31:0] haddr;
    logic [1:0]  htrans;
    logic        hwrite;
    logic [2:0]  hsize;
    logic [2:0]  hburst;
    logic [3:0]  hprot;
    logic        hmastlock;
    logic [31:0] hwdata;
    logic [3:0]  hwstrb;
    logic        ro0, ro3, rs0, rs3;
    logic [31:0] rd0, rd3;
    logic        tgt;
    logic        cur_ready, cur_resp;
    logic [31:0] cur_rdata;

    int checks = 0;
    int errors = 0;

    logic [7:0]  mdl [2][MEMB];
    logic [31:0] bd [4];

    always #5 HCLK = ~HCLK;

    assign cur_ready = tgt ? ro3 : ro0;
    assign cur_resp  = tgt ? rs3 : rs0;
    assign cur_rdata = tgt ? rd3 : rd0;

    ahb_sram_sub #(
        .ADDR_WIDTH(32), .DATA_WIDTH(32), .MEM_BYTES(MEMB), .WAIT_STATES(0)
    ) u_dut0 (
        .HCLK(HCLK), .HRESETn(HRESETn), .HSELx(sel0), .HADDR(haddr), .HTRANS(htrans),
        .HWRITE(hwrite), .HSIZE(hsize), .HBURST(hburst), .HPROT(hprot),
        .HMASTLOCK(hmastlock), .HWDATA(hwdata), .HWSTRB(hwstrb), .HREADY(ro0),
        .HRDATA(rd0), .HREADYOUT(ro0), .HRESP(rs0)
    );

    ahb_sram_sub #(
        .ADDR_WIDTH(32), .DATA_WIDTH(32), .MEM_BYTES(MEMB), .WAIT_STATES(3)
    ) u_dut3 (
        .HCLK(HCLK), .HRESETn(HRESETn), .HSELx(sel3), .HADDR(haddr), .HTRANS(htrans),
        .HWRITE(hwrite), .HSIZE(hsize), .HBURST(hburst), .HPROT(hprot),
        .HMASTLOCK(hmastlock), .HWDATA(hwdata), .HWSTRB(hwstrb), .HREADY(ro3),
        .HRDATA(rd3), .HREADYOUT(ro3), .HRESP(rs3)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference model: bytes [addr, addr+n) that fall in the addressed bus word.
    function automatic bit exp_err(input logic [31:0] a, input logic [2:0] sz);
        int unsigned n = 32'd1 << sz;
        return (a >= MEMB) || ((a % n) != 0) || (n > 4);
    endfunction

    function automatic logic [31:0] exp_read(input bit t, input logic [31:0] a,
                                             input logic [2:0] sz);
        logic [31:0] r = '0;
        int unsigned n = 32'd1 << sz;
        int unsigned base = a & ~32'd3;
        for (int j = 0; j < 4; j++) begin
            if (base + j >= a && base + j < a + n) r[8*j +: 8] = mdl[t][base + j];
        end
        return r;
    endfunction

    task automatic model_write(input bit t, input logic [31:0] a, input logic [2:0] sz,
                               input logic [31:0] wd, input logic [3:0] sb);
        int unsigned n = 32'd1 << sz;
        int unsigned base = a & ~32'd3;
        for (int j = 0; j < 4; j++) begin
            if (base + j >= a && base + j < a + n && sb[j]) mdl[t][base + j] = wd[8*j +: 8];
        end
    endtask

    // Single non-pipelined transfer; starts and ends just after a rising edge.
    task automatic xfer(input bit t, input bit wr, input logic [31:0] a, input logic [2:0] sz,
                        input logic [31:0] wd, input logic [3:0] sb, output int lows,
                        output logic low_resp, output logic resp, output logic [31:0] rdata);
        bit done = 0;
        tgt = t; sel0 = !t; sel3 = t;
        haddr = a; htrans = 2'b10; hwrite = wr; hsize = sz;
        @(posedge HCLK); #1;
        htrans = 2'b00; hwdata = wd; hwstrb = sb;
        lows = 0; low_resp = 1'b0; resp = 1'b0; rdata = '0;
        for (int c = 0; c < 40 && !done; c++) begin
            @(negedge HCLK);
            if (cur_ready) begin
                done = 1; resp = cur_resp; rdata = cur_rdata;
            end else begin
                lows++; low_resp = cur_resp;
            end
            @(posedge HCLK); #1;
        end
        if (!done) begin
            checks++; errors++;
            $display("FAIL xfer_timeout: got no HREADYOUT expected ready within 40 cycles");
        end
        sel0 = 1'b0; sel3 = 1'b0;
    endtask

    task automatic run_check(input string name, input bit t, input bit wr,
                             input logic [31:0] a, input logic [2:0] sz, input logic [31:0] wd,
                             input logic [3:0] sb, input int exp_lows, input bit exp_resp,
                             input logic [31:0] exp_rd);
        int lows;
        logic lr, rs;
        logic [31:0] rd;
        xfer(t, wr, a, sz, wd, sb, lows, lr, rs, rd);
        check({name, ".lows"}, 32'(lows), 32'(exp_lows));
        check({name, ".resp"}, {31'd0, rs}, {31'd0, exp_resp});
        if (exp_lows > 0) check({name, ".lowresp"}, {31'd0, lr}, {31'd0, exp_resp});
        if (!wr) check({name, ".rdata"}, rd, exp_rd);
        if (wr && !exp_resp) model_write(t, a, sz, wd, sb);
    endtask

    typedef struct {
        bit          t;
        bit          wr;
        logic [31:0] a;
        logic [2:0]  sz;
        logic [31:0] wd;
        logic [3:0]  sb;
        int          lows;
        bit          resp;
        logic [31:0] rd;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input bit t, input bit wr, input logic [31:0] a, input logic [2:0] sz,
                       input logic [31:0] wd, input logic [3:0] sb, input int lows,
                       input bit resp, input logic [31:0] rd);
        vec_t v;
        v.t = t; v.wr = wr; v.a = a; v.sz = sz; v.wd = wd; v.sb = sb;
        v.lows = lows; v.resp = resp; v.rd = rd;
        vecs.push_back(v);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        HRESETn = 1'b0; sel0 = 0; sel3 = 0; tgt = 0;
        haddr = '0; htrans = 2'b00; hwrite = 0; hsize = 3'd2;
        hburst = 3'd0; hprot = 4'h3; hmastlock = 0; hwdata = '0; hwstrb = '0;

        // Directed table: t, wr, addr, size, wdata, strb, low cycles, resp, rdata.
        add(0, 1, 32'h10,   2, 32'hDEADBEEF, 4'hF, 0, 0, 32'h0);
        add(0, 0, 32'h10,   2, 32'h0,        4'h0, 0, 0, 32'hDEADBEEF);
        add(0, 1, 32'h13,   0, 32'hAAAAAAAA, 4'hF, 0, 0, 32'h0);
        add(0, 0, 32'h10,   2, 32'h0,        4'h0, 0, 0, 32'hAAADBEEF);
        add(0, 0, 32'h12,   1, 32'h0,        4'h0, 0, 0, 32'hAAAD0000);
        add(0, 0, 32'h11,   0, 32'h0,        4'h0, 0, 0, 32'h0000BE00);
        add(1, 1, 32'h10,   2, 32'h12345678, 4'hF, 3, 0, 32'h0);
        add(1, 0, 32'h10,   2, 32'h0,        4'h0, 3, 0, 32'h12345678);
        add(0, 0, 32'h1000, 2, 32'h0,        4'h0, 1, 1, 32'h0);
        add(0, 1, 32'h20,   2, 32'h0BADF00D, 4'hF, 0, 0, 32'h0);
        add(0, 1, 32'h21,   1, 32'hFFFFFFFF, 4'hF, 1, 1, 32'h0);
        add(0, 0, 32'h20,   2, 32'h0,        4'h0, 0, 0, 32'h0BADF00D);
        add(0, 0, 32'h0,    3, 32'h0,        4'h0, 1, 1, 32'h0);
        add(1, 0, 32'h2000, 2, 32'h0,        4'h0, 1, 1, 32'h0);
        add(0, 1, 32'h14,   2, 32'hFFFFFFFF, 4'hF, 0, 0, 32'h0);
        add(0, 1, 32'h14,   2, 32'h11223344, 4'h5, 0, 0, 32'h0);
        add(0, 0, 32'h14,   2, 32'h0,        4'h0, 0, 0, 32'hFF22FF44);
        add(0, 0, 32'h10,   2, 32'h0,        4'h0, 0, 0, 32'hAAADBEEF);

        repeat (3) @(posedge HCLK);
        #1 HRESETn = 1'b1;
        @(negedge HCLK);
        check("rst.ready0", {31'd0, ro0}, 32'd1);
        check("rst.ready3", {31'd0, ro3}, 32'd1);
        check("rst.resp0",  {31'd0, rs0}, 32'd0);
        check("rst.resp3",  {31'd0, rs3}, 32'd0);
        check("rst.rdata0", rd0, 32'd0);
        check("rst.rdata3", rd3, 32'd0);
        @(posedge HCLK); #1;

        // Give the first 256 bytes of both SRAMs defined contents.
        for (int t = 0; t < 2; t++) begin
            for (int w = 0; w < 64; w++) begin
                run_check($sformatf("init%0d_%0d", t, w), t[0], 1'b1, 32'(4 * w), 3'd2,
                          $urandom, 4'hF, t * 3, 1'b0, 32'h0);
            end
        end

        foreach (vecs[i]) begin
            run_check($sformatf("vec%0d", i), vecs[i].t, vecs[i].wr, vecs[i].a, vecs[i].sz,
                      vecs[i].wd, vecs[i].sb, vecs[i].lows, vecs[i].resp, vecs[i].rd);
        end

        // Pipelined INCR4 writes then reads at 0x40..0x4C on the zero-wait instance.
        for (int i = 0; i < 4; i++) bd[i] = $urandom;
        for (int pass = 0; pass < 2; pass++) begin
            tgt = 0; sel0 = 1'b1; hburst = 3'b011;
            for (int i = 0; i <= 4; i++) begin
                if (i < 4) begin
                    haddr = 32'h40 + 32'(4 * i); htrans = (i == 0) ? 2'b10 : 2'b11;
                    hwrite = (pass == 0); hsize = 3'd2;
                end else begin
                    htrans = 2'b00;
                end
                if (i > 0) begin hwdata = bd[i-1]; hwstrb = 4'hF; end
                @(negedge HCLK);
                if (i > 0) begin
                    check($sformatf("burst%0d_%0d.ready", pass, i), {31'd0, ro0}, 32'd1);
                    check($sformatf("burst%0d_%0d.resp", pass, i), {31'd0, rs0}, 32'd0);
                    if (pass == 1)
                        check($sformatf("burst_rd%0d.rdata", i), rd0,
                              exp_read(1'b0, 32'h40 + 32'(4 * (i - 1)), 3'd2));
                end
                @(posedge HCLK); #1;
                if (i > 0 && pass == 0)
                    model_write(1'b0, 32'h40 + 32'(4 * (i - 1)), 3'd2, bd[i-1], 4'hF);
            end
            sel0 = 1'b0; hburst = 3'd0;
        end

        // Reset during the wait states of a write: the write must be dropped.
        run_check("rstw.pre", 1'b1, 1'b1, 32'h50, 3'd2, 32'h600DCAFE, 4'hF, 3, 1'b0, 32'h0);
        tgt = 1; sel3 = 1'b1; haddr = 32'h50; htrans = 2'b10; hwrite = 1'b1; hsize = 3'd2;
        @(posedge HCLK); #1;
        htrans = 2'b00; hwdata = 32'hBAD0BAD0; hwstrb = 4'hF;
        @(negedge HCLK);
        check("rstw.inwait", {31'd0, ro3}, 32'd0);
        @(posedge HCLK); #1;
        HRESETn = 1'b0;
        @(posedge HCLK); #1;
        HRESETn = 1'b1; sel3 = 1'b0;
        @(negedge HCLK);
        check("rstw.ready", {31'd0, ro3}, 32'd1);
        check("rstw.resp",  {31'd0, rs3}, 32'd0);
        @(posedge HCLK); #1;
        run_check("rstw.read", 1'b1, 1'b0, 32'h50, 3'd2, 32'h0, 4'h0, 3, 1'b0, 32'h600DCAFE);

        // Random transfers against the model.
        for (int k = 0; k < 300; k++) begin
            bit          t  = 1'($urandom_range(0, 1));
            bit          wr = 1'($urandom_range(0, 1));
            int unsigned r  = $urandom_range(0, 9);
            logic [2:0]  sz = (r == 0) ? 3'd3 : 3'($urandom_range(0, 2));
            logic [31:0] a  = 32'($urandom_range(0, 255));
            bit          e;
            if (r != 2) a = a & ~((32'd1 << sz) - 32'd1);
            if (r == 1) a = a + MEMB;
            e = exp_err(a, sz);
            run_check($sformatf("rnd%0d", k), t, wr, a, sz, $urandom, 4'($urandom),
                      e ? 1 : (t ? 3 : 0), e, e ? 32'h0 : exp_read(t, a, sz));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
